// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp_pkg : shared DSP slice types and arithmetic helpers              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dsp_pkg;

  localparam int c_MAX_W = 64;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_t;

  // Replicates bit msb into every higher bit of a c_MAX_W-wide word.
  function automatic logic [c_MAX_W-1:0] sext(input logic [c_MAX_W-1:0] val,
                                              input logic [5:0]         msb);
    logic [c_MAX_W-1:0] upper;
    upper = {c_MAX_W{1'b1}} << msb;
    upper = upper << 1;
    return val[msb] ? (val | upper) : (val & ~upper);
  endfunction

  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp_out_reg : result register with valid/ready hold                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsp_out_reg #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // A load in the same cycle as a take wins, keeping valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= d;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign q     = r_data;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/dsp_acc_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp_acc_out : frame accumulate-and-drain stage with overflow flag    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsp_acc_out #(
  parameter int DW   = 36,
  parameter int PW   = 48,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LENW-1:0] len,
  output logic [PW-1:0]   out_data,
  output logic            out_ovf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  import dsp_pkg::*;

  acc_state_t      r_state;
  logic [PW-1:0]   r_acc;
  logic [LENW-1:0] r_cnt;
  logic [LENW-1:0] r_len;
  logic            r_ovf;

  logic [PW-1:0]   w_x;
  logic [PW-1:0]   w_sum;
  logic            w_add_ovf;
  logic [LENW-1:0] w_len_eff;
  logic            w_is_last;
  logic            w_acc_en;
  logic            w_load;
  logic [PW:0]     w_load_data;
  logic [PW:0]     w_out_q;

  assign w_x       = PW'(sext(c_MAX_W'(in_data), 6'(DW - 1)));
  assign w_sum     = r_acc + w_x;
  assign w_add_ovf = signed_ovf(r_acc[PW-1], w_x[PW-1], w_sum[PW-1]);

  assign w_len_eff = (len == '0) ? LENW'(1) : len;
  assign w_is_last = (r_state == ST_IDLE) ? (w_len_eff == LENW'(1))
                                          : (r_cnt == r_len - LENW'(1));

  // Only the closing sample needs the output slot, so only it stalls.
  assign in_ready = ce & ~(w_is_last & out_valid & ~out_ready);
  assign w_acc_en = in_valid & in_ready;

  assign w_load      = w_acc_en & w_is_last;
  assign w_load_data = (r_state == ST_IDLE) ? {1'b0, w_x}
                                            : {r_ovf | w_add_ovf, w_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_acc_en) begin
      case (r_state)
        ST_IDLE: begin
          r_len <= w_len_eff;
          if (!w_is_last) begin
            r_acc   <= w_x;
            r_ovf   <= 1'b0;
            r_cnt   <= LENW'(1);
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (!w_is_last) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LENW'(1);
            r_ovf <= r_ovf | w_add_ovf;
          end else begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dsp_out_reg #(
    .W (PW + 1)
  ) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .d     (w_load_data),
    .ready (out_ready),
    .q     (w_out_q),
    .valid (out_valid)
  );

  assign out_ovf  = w_out_q[PW];
  assign out_data = w_out_q[PW-1:0];
  assign busy     = (r_state == ST_ACC);

endmodule
`default_nettype wire
